// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage with IF/ID register, one-entry skid buffer and
//   redirect handling for requests that are still outstanding.
//
//   Ports
//     clk          : clock, all state updates on the rising edge
//     rst          : asynchronous active-high reset
//     imem_addr    : word-aligned fetch address (the pc register)
//     imem_req     : fetch request, low in HOLD and while rst is high
//     imem_ready   : memory completion, imem_rdata valid in the same cycle
//     imem_rdata   : fetched instruction word
//     stall        : hazard hold for the IF/ID register
//     redirect     : taken branch or jump from a later stage
//     redirect_pc  : branch or jump target (bits[1:0] ignored)
//     instr        : IF/ID instruction register (0 when not valid)
//     pc_plus4     : IF/ID PC+4 for the instruction in instr
//     valid        : instr holds a live instruction
//     Opcode/funct : instr[31:26] / instr[5:0] for the control decoder
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic [5:0]  Opcode,
    output logic [5:0]  funct
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] pend_q, pend_d;

    logic [31:0] pc_inc;
    logic [31:0] redir_aligned;

    // Natural 32-bit wrap gives 0xFFFFFFFC + 4 = 0.
    assign pc_inc        = pc_q + 32'd4;
    assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        pend_d       = pend_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    // Redirect beats stall: flush IF/ID to a NOP immediately.
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                    if (imem_ready) begin
                        pc_d = redir_aligned;
                    end else begin
                        // Request in flight must complete before the new
                        // address can be presented.
                        pend_d  = redir_aligned;
                        state_d = ST_DISCARD;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (stall && valid_q) begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_inc;
                        state_d      = ST_HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_inc;
                        valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    // Decode consumed the instruction and nothing replaces
                    // it this cycle: insert a bubble.
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redir_aligned;
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_DISCARD: begin
                // Latest redirect wins, including one arriving together with
                // the completion being dropped.
                if (redirect) begin
                    pend_d = redir_aligned;
                end
                if (imem_ready) begin
                    pc_d    = redirect ? redir_aligned : pend_q;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC_ALIGNED;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
            pend_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            pend_q       <= pend_d;
        end
    end

    assign imem_req  = (state_q != ST_HOLD) && !rst;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc_plus4  = pc4_q;
    assign valid     = valid_q;
    assign Opcode    = instr_q[31:26];
    assign funct     = instr_q[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Bench for fetch_unit: directed scenarios followed by randomized traffic,
//   all checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] imem_addr, instr, pc_plus4;
    logic        imem_req, valid;
    logic [5:0]  Opcode, funct;

    logic [31:0] d2_addr, d2_instr, d2_pc4;
    logic        d2_req, d2_valid;
    logic [5:0]  d2_op, d2_fn;

    localparam logic [31:0] ALT_RESET_PC = 32'h00400000;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .pc_plus4(pc_plus4), .valid(valid),
        .Opcode(Opcode), .funct(funct)
    );

    fetch_unit #(.RESET_PC(ALT_RESET_PC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_addr(d2_addr), .imem_req(d2_req),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(d2_instr), .pc_plus4(d2_pc4), .valid(d2_valid),
        .Opcode(d2_op), .funct(d2_fn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: the stage is described by what it is holding --
    // the address to fetch next, the IF/ID contents, an optional parked
    // instruction, and an optional "drop the next completion" target.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic        m_parked;
    logic [31:0] m_park_instr, m_park_pc4;
    logic        m_dropping;
    logic [31:0] m_target;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_parked = 1'b0; m_park_instr = 32'h0; m_park_pc4 = 32'h0;
        m_dropping = 1'b0; m_target = 32'h0;
    endtask

    task automatic model_step(input logic rdy, input logic st, input logic rd,
                              input logic [31:0] rpc, input logic [31:0] dat);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (m_parked) begin
            if (rd) begin
                m_pc = tgt; m_parked = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
            end else if (!st) begin
                m_instr = m_park_instr; m_pc4 = m_park_pc4; m_valid = 1'b1;
                m_parked = 1'b0;
            end
        end else if (m_dropping) begin
            if (rd) m_target = tgt;
            if (rdy) begin
                m_pc = m_target; m_dropping = 1'b0;
            end
        end else if (rd) begin
            m_valid = 1'b0; m_instr = 32'h0;
            if (rdy) m_pc = tgt;
            else begin
                m_target = tgt; m_dropping = 1'b1;
            end
        end else if (rdy) begin
            if (st && m_valid) begin
                m_park_instr = dat; m_park_pc4 = m_pc + 32'd4; m_parked = 1'b1;
            end else begin
                m_instr = dat; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, "_req"},    {31'h0, imem_req}, {31'h0, !m_parked});
        check({ph, "_addr"},   imem_addr, m_pc);
        check({ph, "_valid"},  {31'h0, valid}, {31'h0, m_valid});
        check({ph, "_instr"},  instr, m_instr);
        check({ph, "_opcode"}, {26'h0, Opcode}, {26'h0, m_instr[31:26]});
        check({ph, "_funct"},  {26'h0, funct}, {26'h0, m_instr[5:0]});
        if (m_valid) check({ph, "_pc4"}, pc_plus4, m_pc4);
    endtask

    // One clock: drive at the falling edge, check combinational request,
    // let the rising edge happen, then check the registered state.
    task automatic cycle(input logic rdy, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic [31:0] dat);
        @(negedge clk);
        imem_ready = rdy; stall = st; redirect = rd; redirect_pc = rpc; imem_rdata = dat;
        #1;
        check("pre_req",  {31'h0, imem_req}, {31'h0, !m_parked});
        check("pre_addr", imem_addr, m_pc);
        @(posedge clk);
        model_step(rdy, st, rd, rpc, dat);
        #1;
        check_outputs("post");
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_req",    {31'h0, imem_req}, 32'h0);
        check("rst_addr",   imem_addr, 32'h0);
        check("rst_valid",  {31'h0, valid}, 32'h0);
        check("rst_instr",  instr, 32'h0);
        check("rst_pc4",    pc_plus4, 32'h0);
        check("rst2_req",   {31'h0, d2_req}, 32'h0);
        check("rst2_addr",  d2_addr, ALT_RESET_PC);
        check("rst2_valid", {31'h0, d2_valid}, 32'h0);
        check("rst2_instr", d2_instr, 32'h0);
        check("rst2_pc4",   d2_pc4, 32'h0);
        check("rst2_opfn",  {20'h0, d2_op, d2_fn}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_req",   {31'h0, imem_req}, 32'h1);
        check("rel_addr",  imem_addr, 32'h0);
        check("rel2_req",  {31'h0, d2_req}, 32'h1);
        check("rel2_addr", d2_addr, ALT_RESET_PC);
    endtask

    initial begin
        logic rdy, st, rd;
        logic [31:0] rpc, dat;

        model_reset();
        do_reset();

        // Back-to-back fetches with zero-wait memory.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, memval(m_pc));
            check("seq_pc4", pc_plus4, 32'd4 * (i + 1));
            check("seq_valid", {31'h0, valid}, 32'h1);
        end

        // Stall with live IF/ID parks the returned word.
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h8C220004);
        check("hold_req", {31'h0, imem_req}, 32'h0);
        check("hold_instr", instr, memval(32'h8));
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("hold2_instr", instr, memval(32'h8));
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("unpark_instr", instr, 32'h8C220004);
        check("unpark_opcode", {26'h0, Opcode}, {26'h0, 6'b100011});

        // Redirect while the 0x10 request is outstanding.
        cycle(1'b0, 1'b0, 1'b1, 32'h00000040, 32'h0);
        check("disc_valid", {31'h0, valid}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("disc_addr", imem_addr, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, memval(32'h10));
        check("redir_addr", imem_addr, 32'h40);
        check("redir_valid", {31'h0, valid}, 32'h0);

        // Redirect together with stall flushes IF/ID.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, memval(m_pc));
        cycle(1'b1, 1'b1, 1'b1, 32'h00000080, memval(m_pc));
        check("flush_valid", {31'h0, valid}, 32'h0);
        check("flush_instr", instr, 32'h0);
        check("flush_opfn", {20'h0, Opcode, funct}, 32'h0);
        check("flush_addr", imem_addr, 32'h80);

        // Unaligned target, then address wrap at the top of memory.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
        check("top_addr", imem_addr, 32'hFFFFFFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, memval(m_pc));
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", pc_plus4, 32'h0);

        // Reset asserted while parked in HOLD.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, memval(m_pc));
        cycle(1'b1, 1'b1, 1'b0, 32'h0, memval(m_pc));
        check("prerst2_req", {31'h0, d2_req}, 32'h0);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                rdy = m_parked ? 1'b0 : ($urandom_range(0, 2) != 0);
                st  = ($urandom_range(0, 4) < 2);
                rd  = ($urandom_range(0, 9) == 0);
                rpc = $urandom;
                dat = $urandom;
                cycle(rdy, st, rd, rpc, dat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port imem_addr, output, 32, the instruction memory word address (byte address, bits[1:0]=00).
REQ-005 The block SHALL have port imem_req, output, 1, the fetch request to instruction memory.
REQ-006 The block SHALL have port imem_ready, input, 1, memory completion; imem_rdata is valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-008 The block SHALL have port stall, input, 1, the hazard hold for the IF/ID register.
REQ-009 The block SHALL have port redirect, input, 1, a taken branch or jump from the later stage.
REQ-010 The block SHALL have port redirect_pc, input, 32, the branch or jump target.
REQ-011 The block SHALL have port instr, output, 32, the IF/ID instruction register.
REQ-012 The block SHALL have port pc_plus4, output, 32, the IF/ID PC+4 register for the instruction in instr.
REQ-013 The block SHALL have port valid, output, 1, meaning instr holds a live instruction.
REQ-014 The block SHALL have ports Opcode, output, 6, equal to instr[31:26], and funct, output, 6, equal to instr[5:0], both combinational, feeding the control decoder.

Function
REQ-015 The block SHALL implement FSM states FETCH, DISCARD and HOLD, with FETCH as the reset state.
REQ-016 imem_req SHALL be 1 in FETCH and DISCARD and 0 in HOLD or while rst=1; imem_addr SHALL equal the pc register; pc SHALL hold stable while imem_req=1 and imem_ready=0.
REQ-017 In FETCH, if imem_ready=1 and (stall=0 or valid=0), the block SHALL load instr<=imem_rdata, pc_plus4<=pc+4, valid<=1 and pc<=pc+4 at the same edge, staying in FETCH; data-to-output latency is 1 cycle.
REQ-018 In FETCH, if imem_ready=1 and stall=1 and valid=1, the block SHALL capture imem_rdata and pc+4 into a one-entry skid buffer, set pc<=pc+4, and go to HOLD.
REQ-019 In HOLD, when stall=0, the block SHALL move the skid buffer into instr/pc_plus4 with valid=1 and go to FETCH.
REQ-020 In FETCH with imem_ready=0 and stall=1, IF/ID SHALL hold unchanged.
REQ-021 On redirect=1 in FETCH with imem_ready=0, the block SHALL latch redirect_pc into a pending-target register and go to DISCARD.
REQ-022 On redirect=1 in FETCH with imem_ready=1, or in HOLD, the block SHALL set pc<=redirect_pc, drop any returned or buffered data, and go to or stay in FETCH.
REQ-023 In DISCARD, on imem_ready=1, the block SHALL drop the data, set pc<=pending target, and go to FETCH; a further redirect in DISCARD SHALL overwrite the pending target (latest wins).
REQ-024 Redirect SHALL take priority over stall: at the same edge valid<=0 and instr<=32'h00000000 (NOP), so control never sees a stale live opcode.
REQ-025 With valid=0, instr SHALL read 32'h00000000.
REQ-026 redirect_pc[1:0] SHALL be ignored, with pc forced to 00 in bits[1:0].
REQ-027 pc+4 SHALL wrap modulo 2^32, so 32'hFFFFFFFC advances to 32'h00000000.

Reset
REQ-028 While rst=1 the block SHALL asynchronously set pc=RESET_PC, state=FETCH, instr=0, pc_plus4=0, valid=0, skid buffer and pending target cleared, and imem_req=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; the first imem_req after rst falls SHALL present RESET_PC.

Verification
REQ-030 Release reset; memory ready on the same cycle each request -> addresses 0,4,8 on consecutive cycles; instr sequence matches; pc_plus4 = 4,8,12; valid=1 from the second cycle.
REQ-031 Memory returns 32'h8C220004 with stall=1 and valid=1 -> HOLD, imem_req=0, instr unchanged; stall=0 -> instr=32'h8C220004, Opcode=6'b100011.
REQ-032 redirect=1, redirect_pc=32'h00000040, while a request to 0x10 is pending for 3 cycles -> the 0x10 data is dropped; next imem_addr=0x40; valid=0 meanwhile.
REQ-033 redirect and stall asserted together with valid=1 -> next cycle valid=0, instr=0, Opcode=0, funct=0.
REQ-034 pc=32'hFFFFFFFC fetch completes -> imem_addr=0x00000000, pc_plus4=0.
REQ-035 rst pulsed during HOLD with RESET_PC=32'h00400000 -> all outputs cleared; first request after release is at 0x00400000.
